cmp_arbiter: RTL
================

CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits; only 4 is supported.
REQ-002 CLOCK_50  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req0  input  1  requester 0 request; level-sensitive.
REQ-005 a0  input  4  requester 0 operand A.
REQ-006 b0  input  4  requester 0 operand B.
REQ-007 op0  input  2  requester 0 operation: 00 equal, 01 greater, 10 less-or-equal, 11 max.
REQ-008 gnt0  output  1  one-cycle grant pulse to requester 0; operands captured.
REQ-009 done0  output  1  one-cycle completion pulse to requester 0.
REQ-010 res0  output  4  requester 0 result; valid while done0 is high, held until the next done0.
REQ-011 req1, a1, b1, op1, gnt1, done1, res1: identical to REQ-004..REQ-010, for requester 1.
REQ-012 busy  output  1  high whenever the FSM is not in IDLE.
REQ-013 cnt0, cnt1  output  8 each  completed-operation counters; present only under CMP_ARB_CNT_EN.

Function
REQ-014 One shared comparator unit is time-multiplexed between two requesters.
REQ-015 The FSM has three states: IDLE, EXEC, RESP; IDLE->EXEC on any sampled request, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016 At an edge in IDLE with a request, the arbiter selects one requester, latches its a, b and op, enters EXEC and drives that requester's gnt high for exactly the EXEC cycle.
REQ-017 Arbitration is round-robin:
- If only one requester is asserting, that requester is granted.
- If both are asserting, the requester not granted last is granted.
- The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-018 Results are computed on the latched operands, treated as unsigned 4-bit values, and zero-extended to 4 bits:
- Equal: res = {3'b000, A==B}.
- Greater: res = {3'b000, A>B}.
- Less-or-equal: res = {3'b000, A<=B}.
- Max: res = the larger of A and B (A when equal).
REQ-019 Timing of a granted operation:
- At the EXEC edge the result is registered into the granted requester's res and the FSM enters RESP.
- The granted requester's done is high for exactly the RESP cycle.
- The other requester's res and done are unaffected.
REQ-020 Latency: done is asserted 2 cycles after the sampling edge; throughput is at most one operation per 3 cycles.
REQ-021 Requests are not sampled in EXEC or RESP.
REQ-022 A requester that still holds req in the next IDLE cycle is treated as a new request, using the operand values present at that edge.
REQ-023 Changes to a, b or op after the capture edge do not affect the in-flight result.
REQ-024 gnt0/gnt1 are never high in the same cycle, and done0/done1 are never high in the same cycle.

Reset
REQ-025 When rst is sampled high, the FSM enters IDLE on that edge, regardless of state.
REQ-026 Reset values:
- gnt0, gnt1, done0, done1 and busy = 0.
- res0, res1 = 4'h0.
- Latched operands = 0.
- Last-grant pointer = 1.
- cnt0, cnt1 = 0 (when present).
REQ-027 An operation in flight when reset is asserted is discarded; no done is issued for it.
REQ-028 Requests sampled during the reset cycle are ignored.

Configuration
REQ-029 Macro CMP_ARB_CNT_EN controls the completion counters.
REQ-030 With CMP_ARB_CNT_EN defined:
- cnt0/cnt1 increment by 1 in the cycle after their requester's done pulse.
- Each counter saturates at 255.
- Counters clear only on reset.
REQ-031 Without CMP_ARB_CNT_EN, ports cnt0/cnt1 and their registers do not exist; all other behaviour is identical.

Verification
REQ-032 Single request: req0=1, a0=5, b0=9, op0=11 -> gnt0 high 1 cycle after the sampling edge, done0 high 2 cycles after it, res0=4'h9.
REQ-033 Ops sweep, requester 1: a1=7, b1=7 -> op 00 gives res1=1, op 01 gives 0, op 10 gives 1, op 11 gives 4'h7.
REQ-034 Tie after reset: req0 and req1 held high together -> grants alternate 0,1,0,1 at 3-cycle spacing; done0 and done1 are never coincident.
REQ-035 Operand change after capture: a0 changes from 3 to 15 in the EXEC cycle with op0=01, b0=4 -> res0=0.
REQ-036 Reset mid-op: rst asserted during EXEC -> no done pulse, res0/res1=0, busy=0 on the next cycle, and the next tie grants requester 0.
REQ-037 With CMP_ARB_CNT_EN: 300 back-to-back requester-0 ops -> cnt0=255, cnt1=0.

Source files
------------

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter sharing one 4-bit unsigned comparator (IDLE/EXEC/RESP).
// Define CMP_ARB_CNT_EN to add the saturating per-requester completion counters cnt0/cnt1.
module cmp_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [1:0]       op0,
    output logic             gnt0,
    output logic             done0,
    output logic [WIDTH-1:0] res0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op1,
    output logic             gnt1,
    output logic             done1,
    output logic [WIDTH-1:0] res1,
`ifdef CMP_ARB_CNT_EN
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q;
    logic             last_q;
    logic             grant_sel;
    logic             any_req;
    logic [WIDTH-1:0] a_q, b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] res0_q, res1_q;
    logic [WIDTH-1:0] alu_res;

    function automatic logic [WIDTH-1:0] cmp_op(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = {{(WIDTH-1){1'b0}}, (a == b)};
            2'b01:   r = {{(WIDTH-1){1'b0}}, (a > b)};
            2'b10:   r = {{(WIDTH-1){1'b0}}, (a <= b)};
            default: r = (a >= b) ? a : b;
        endcase
        return r;
    endfunction

    assign any_req = req0 | req1;
    // On a tie the requester that did not win last time gets the unit.
    assign grant_sel = (req0 && req1) ? ~last_q : req1;
    assign alu_res   = cmp_op(a_q, b_q, op_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            res0_q  <= '0;
            res1_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                sel_q  <= grant_sel;
                last_q <= grant_sel;
                a_q    <= grant_sel ? a1  : a0;
                b_q    <= grant_sel ? b1  : b0;
                op_q   <= grant_sel ? op1 : op0;
            end
            if (state_q == EXEC) begin
                if (sel_q) res1_q <= alu_res;
                else       res0_q <= alu_res;
            end
        end
    end

`ifdef CMP_ARB_CNT_EN
    logic [7:0] cnt0_q, cnt1_q;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else if (state_q == RESP) begin
            if (!sel_q && cnt0_q != 8'hFF) cnt0_q <= cnt0_q + 8'd1;
            if ( sel_q && cnt1_q != 8'hFF) cnt1_q <= cnt1_q + 8'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

    assign gnt0  = (state_q == EXEC) && !sel_q;
    assign gnt1  = (state_q == EXEC) &&  sel_q;
    assign done0 = (state_q == RESP) && !sel_q;
    assign done1 = (state_q == RESP) &&  sel_q;
    assign res0  = res0_q;
    assign res1  = res1_q;
    assign busy  = (state_q != IDLE);

endmodule
